leaf_out_arbiter: RTL and testbench

- Parametrised leaf-side egress stage. Merges NUM_OUT_PORTS HLS output streams (ap_vld/ap_ack) into one BFT packet stream.
- Holds a per-channel destination table that is programmed in-band from the network.
- Enforces per-channel credit flow control against the receiver's BRAM depth, stamps per-channel sequence addresses, and arbitrates round-robin.
- Sits between user operator outputs and the BFT egress port of a leaf.

---
 rtl/leaf_out_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter.sv
// Leaf egress arbiter: merges NUM_OUT_PORTS ap_vld/ap_ack streams into one BFT packet stream
// with an in-band programmed destination table, per-channel credits and sequence addresses.
// Optional statistics outputs are enabled by defining LEAF_OUT_ARB_STATS_EN.
module leaf_out_arbiter #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 4,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_OUT_PORTS = 4,
    parameter int PACKET_BITS   = PAYLOAD_BITS + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user,
    output logic [NUM_OUT_PORTS-1:0]              ack_user,
    input  logic [PACKET_BITS-1:0]                din_cfg,
    output logic [PACKET_BITS-1:0]                dout_bft,
    input  logic                                  bft_ready
`ifdef LEAF_OUT_ARB_STATS_EN
    ,
    output logic [31:0]                           stat_pkt_cnt,
    output logic [31:0]                           stat_block_cnt
`endif
);

    localparam int IDX_W     = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CW        = NUM_ADDR_BITS + 1;
    localparam int ADDR_LSB  = PAYLOAD_BITS;
    localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
    localparam int VALID_BIT = PACKET_BITS - 1;
    localparam int CTRL_BIT  = PACKET_BITS - 2;
    localparam logic [CW-1:0] CREDIT_MAX = {1'b1, {NUM_ADDR_BITS{1'b0}}};

    logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] leaf_d   [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] port_q   [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] port_d   [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_d    [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
    logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] cfgd_q, cfgd_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;

    logic [NUM_OUT_PORTS-1:0] elig;
    logic                     any_elig;
    logic                     found;
    logic                     slot_free;
    logic [IDX_W-1:0]         grant;
    logic [PAYLOAD_BITS-1:0]  send_payload;
    logic [PACKET_BITS-1:0]   send_pkt;
    logic                     cfg_hit;
    logic                     cfg_is_credit;
    logic [NUM_PORT_BITS-1:0] cfg_chan;
    logic [CW-1:0]            cfg_amount;
    logic [CW:0]              credit_sum;
    logic                     cfg_unused;

    assign cfg_hit       = din_cfg[VALID_BIT] & din_cfg[CTRL_BIT];
    assign cfg_is_credit = din_cfg[PAYLOAD_BITS-1];
    assign cfg_chan      = din_cfg[PORT_LSB +: NUM_PORT_BITS];
    assign cfg_amount    = din_cfg[NUM_ADDR_BITS:0];
    assign cfg_unused    = ^din_cfg;
    assign dout_bft      = dout_q;

    // Round-robin: first eligible channel above last_q, otherwise wrap to the lowest eligible.
    always_comb begin
        slot_free = ~dout_q[VALID_BIT] | bft_ready;
        for (int unsigned c = 0; c < NUM_OUT_PORTS; c++) begin
            elig[c] = vld_user[c] & cfgd_q[c] & (credit_q[c] != '0);
        end
        any_elig = |elig;
        found    = 1'b0;
        grant    = '0;
        for (int unsigned c = 0; c < NUM_OUT_PORTS; c++) begin
            if (!found && elig[c] && (IDX_W'(c) > last_q)) begin
                found = 1'b1;
                grant = IDX_W'(c);
            end
        end
        for (int unsigned c = 0; c < NUM_OUT_PORTS; c++) begin
            if (!found && elig[c]) begin
                found = 1'b1;
                grant = IDX_W'(c);
            end
        end
        send_payload = '0;
        for (int unsigned c = 0; c < NUM_OUT_PORTS; c++) begin
            if (grant == IDX_W'(c)) begin
                send_payload = din_user[c*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
        send_pkt = {1'b1, 1'b0, leaf_q[grant], port_q[grant], seq_q[grant], send_payload};
        ack_user = '0;
        if (slot_free && any_elig) begin
            ack_user[grant] = 1'b1;
        end
    end

    // Config is applied after the send so SET_DEST overrides and CREDIT adds to the decremented count.
    always_comb begin
        leaf_d     = leaf_q;
        port_d     = port_q;
        seq_d      = seq_q;
        credit_d   = credit_q;
        cfgd_d     = cfgd_q;
        last_d     = last_q;
        dout_d     = dout_q;
        credit_sum = '0;
        if (slot_free) begin
            if (any_elig) begin
                dout_d          = send_pkt;
                last_d          = grant;
                seq_d[grant]    = seq_q[grant] + 1'b1;
                credit_d[grant] = credit_q[grant] - 1'b1;
            end else begin
                dout_d[VALID_BIT] = 1'b0;
            end
        end
        if (cfg_hit) begin
            for (int unsigned c = 0; c < NUM_OUT_PORTS; c++) begin
                if (cfg_chan == NUM_PORT_BITS'(c)) begin
                    if (cfg_is_credit) begin
                        credit_sum  = {1'b0, credit_d[c]} + {1'b0, cfg_amount};
                        credit_d[c] = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX
                                                                         : credit_sum[CW-1:0];
                    end else begin
                        leaf_d[c]   = din_cfg[NUM_PORT_BITS +: NUM_LEAF_BITS];
                        port_d[c]   = din_cfg[NUM_PORT_BITS-1:0];
                        cfgd_d[c]   = 1'b1;
                        seq_d[c]    = '0;
                        credit_d[c] = CREDIT_MAX;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= '0;
            last_q <= IDX_W'(NUM_OUT_PORTS - 1);
            cfgd_q <= '0;
            for (int unsigned c = 0; c < NUM_OUT_PORTS; c++) begin
                leaf_q[c]   <= '0;
                port_q[c]   <= '0;
                seq_q[c]    <= '0;
                credit_q[c] <= CREDIT_MAX;
            end
        end else begin
            dout_q   <= dout_d;
            last_q   <= last_d;
            cfgd_q   <= cfgd_d;
            leaf_q   <= leaf_d;
            port_q   <= port_d;
            seq_q    <= seq_d;
            credit_q <= credit_d;
        end
    end

`ifdef LEAF_OUT_ARB_STATS_EN
    logic [31:0] stat_pkt_q, stat_pkt_d;
    logic [31:0] stat_block_q, stat_block_d;
    logic        blocked;

    always_comb begin
        blocked = 1'b0;
        for (int unsigned c = 0; c < NUM_OUT_PORTS; c++) begin
            if (vld_user[c] && cfgd_q[c] && (credit_q[c] == '0)) begin
                blocked = 1'b1;
            end
        end
        stat_pkt_d   = stat_pkt_q + {31'd0, dout_q[VALID_BIT] & bft_ready};
        stat_block_d = stat_block_q + {31'd0, blocked};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pkt_q   <= '0;
            stat_block_q <= '0;
        end else begin
            stat_pkt_q   <= stat_pkt_d;
            stat_block_q <= stat_block_d;
        end
    end

    assign stat_pkt_cnt   = stat_pkt_q;
    assign stat_block_cnt = stat_block_q;
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scoreboard bench for leaf_out_arbiter: stimulus pushes expected egress packets,
// a negedge monitor pops and compares every packet the network accepts.
module tb_leaf_out_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] din_user;
    logic [3:0]   vld_user;
    logic [3:0]   ack_user;
    logic [48:0]  din_cfg;
    logic [48:0]  dout_bft;
    logic         bft_ready;
`ifdef LEAF_OUT_ARB_STATS_EN
    logic [31:0]  stat_pkt_cnt;
    logic [31:0]  stat_block_cnt;
    logic [31:0]  blk_snap;
`endif

    leaf_out_arbiter #(
        .PAYLOAD_BITS (32),
        .NUM_LEAF_BITS(4),
        .NUM_PORT_BITS(4),
        .NUM_ADDR_BITS(7),
        .NUM_OUT_PORTS(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din_user (din_user),
        .vld_user (vld_user),
        .ack_user (ack_user),
        .din_cfg  (din_cfg),
        .dout_bft (dout_bft),
        .bft_ready(bft_ready)
`ifdef LEAF_OUT_ARB_STATS_EN
        ,
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_block_cnt(stat_block_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [48:0] sb[$];
    logic [48:0] mexp;
    logic [48:0] p_hold;
    logic [3:0]  m_leaf[4];
    logic [3:0]  m_port[4];
    logic [6:0]  m_seq[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [48:0] mkpkt(input int c);
        logic [31:0] d;
        d = din_user[c*32 +: 32];
        return {1'b1, 1'b0, m_leaf[c], m_port[c], m_seq[c], d};
    endfunction

    function automatic logic [48:0] cfgpkt(input logic [3:0] k, input logic [31:0] pl);
        return {1'b1, 1'b1, 4'h0, k, 7'h0, pl};
    endfunction

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle(input logic [3:0] exp_ack, input logic [48:0] exp_pkt, input string name);
        #1;
        chk(name, {60'd0, ack_user}, {60'd0, exp_ack});
        if (exp_ack != 4'd0) begin
            sb.push_back(exp_pkt);
            for (int i = 0; i < 4; i++) if (exp_ack[i]) m_seq[i] = m_seq[i] + 7'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic set_dest(input logic [3:0] k, input logic [3:0] leaf, input logic [3:0] port);
        din_cfg = cfgpkt(k, {24'd0, leaf, port});
        @(posedge clk); #1;
        din_cfg = '0;
        m_leaf[k] = leaf;
        m_port[k] = port;
        m_seq[k]  = 7'd0;
    endtask

    always @(negedge clk) begin
        if (reset && dout_bft[48] && bft_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pkt: got %h expected none", dout_bft);
            end else begin
                mexp = sb.pop_front();
                chk("egress_pkt", {15'd0, dout_bft}, {15'd0, mexp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; din_user = '0; vld_user = '0; din_cfg = '0; bft_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin m_leaf[i] = '0; m_port[i] = '0; m_seq[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", {15'd0, dout_bft}, 64'd0);
        chk("reset_ack", {60'd0, ack_user}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic send on channel 0 with hand-computed packets.
        set_dest(4'd0, 4'h3, 4'h2);
        vld_user = 4'b0001; din_user[31:0] = 32'hDEADBEEF;
        cycle(4'b0001, 49'h1_1900_DEAD_BEEF, "ch0_first_ack");
        din_user[31:0] = 32'h12345678;
        cycle(4'b0001, 49'h1_1901_1234_5678, "ch0_second_ack");
        vld_user = '0;
        cycle(4'b0000, '0, "idle_ack");
        #1 chk("idle_valid_clear", {63'd0, dout_bft[48]}, 64'd0);

        // Round robin across all four channels; last grant was channel 0.
        set_dest(4'd1, 4'h1, 4'h5);
        set_dest(4'd2, 4'h2, 4'h6);
        set_dest(4'd3, 4'h4, 4'h7);
        for (int c = 0; c < 4; c++) din_user[c*32 +: 32] = 32'hA000_0000 + 32'(c);
        vld_user = 4'b1111;
        cycle(4'b0010, mkpkt(1), "rr_grant1");
        cycle(4'b0100, mkpkt(2), "rr_grant2");
        cycle(4'b1000, mkpkt(3), "rr_grant3");
        cycle(4'b0001, mkpkt(0), "rr_grant0");
        cycle(4'b0010, mkpkt(1), "rr_grant1_again");
        vld_user = '0;
        cycle(4'b0000, '0, "rr_idle");

        // Credit exhaustion, then a CREDIT of 5 with address wrap.
        set_dest(4'd1, 4'h1, 4'h5);
        vld_user = 4'b0010;
        for (int i = 0; i < 128; i++) begin
            din_user[63:32] = 32'(i);
            cycle(4'b0010, mkpkt(1), "credit_burst");
        end
        cycle(4'b0000, '0, "credit_zero_block");
        din_cfg = cfgpkt(4'd1, 32'h8000_0005);
        cycle(4'b0000, '0, "credit_cfg_cycle");
        din_cfg = '0;
        for (int i = 0; i < 5; i++) begin
            din_user[63:32] = 32'h0000_1000 + 32'(i);
            cycle(4'b0010, mkpkt(1), "credit_refill");
        end
        cycle(4'b0000, '0, "credit_refill_exhausted");
        vld_user = '0;
        cycle(4'b0000, '0, "credit_idle");

        // Back-pressure: packet held stable while bft_ready is low.
        vld_user = 4'b0100; din_user[95:64] = 32'hC0FFEE00;
        p_hold = mkpkt(2);
        cycle(4'b0100, p_hold, "stall_first");
        bft_ready = 1'b0; din_user[95:64] = 32'hC0FFEE01;
        for (int i = 0; i < 4; i++) begin
            #1 chk("stall_hold", {15'd0, dout_bft}, {15'd0, p_hold});
            #1;
            chk("stall_ack", {60'd0, ack_user}, 64'd0);
            @(posedge clk); #1;
        end
        bft_ready = 1'b1;
        cycle(4'b0100, mkpkt(2), "stall_release");
        vld_user = '0;
        cycle(4'b0000, '0, "stall_idle");

        // Same-cycle CREDIT(+3) and grant on channel 2 holding one credit.
        set_dest(4'd2, 4'h2, 4'h6);
        vld_user = 4'b0100;
        for (int i = 0; i < 127; i++) begin
            din_user[95:64] = 32'h2200_0000 + 32'(i);
            cycle(4'b0100, mkpkt(2), "ch2_drain");
        end
`ifdef LEAF_OUT_ARB_STATS_EN
        blk_snap = stat_block_cnt;
`endif
        din_cfg = cfgpkt(4'd2, 32'h8000_0003);
        cycle(4'b0100, mkpkt(2), "same_cycle_credit_grant");
        din_cfg = '0;
        for (int i = 0; i < 3; i++) cycle(4'b0100, mkpkt(2), "post_credit_grant");
`ifdef LEAF_OUT_ARB_STATS_EN
        chk("block_cnt_steady", {32'd0, stat_block_cnt}, {32'd0, blk_snap});
`endif
        cycle(4'b0000, '0, "post_credit_block");
        vld_user = '0;
        cycle(4'b0000, '0, "post_credit_idle");

        // Same-cycle SET_DEST and grant on channel 3: old entry used, new table afterwards.
        vld_user = 4'b1000; din_user[127:96] = 32'h3333_0000;
        din_cfg = cfgpkt(4'd3, 32'h0000_0091);
        cycle(4'b1000, mkpkt(3), "same_cycle_setdest_grant");
        din_cfg = '0;
        m_leaf[3] = 4'h9; m_port[3] = 4'h1; m_seq[3] = 7'd0;
        din_user[127:96] = 32'h3333_0001;
        cycle(4'b1000, mkpkt(3), "after_setdest_grant");
        vld_user = '0;
        cycle(4'b0000, '0, "setdest_idle");

        // Reset mid-stream.
        vld_user = 4'b0001; din_user[31:0] = 32'h5555_0000;
        cycle(4'b0001, mkpkt(0), "pre_reset_send");
        reset = 1'b0;
        sb.delete();
        #1;
        chk("midreset_dout", {15'd0, dout_bft}, 64'd0);
        chk("midreset_ack", {60'd0, ack_user}, 64'd0);
        for (int i = 0; i < 4; i++) begin m_leaf[i] = '0; m_port[i] = '0; m_seq[i] = '0; end
        @(posedge clk); #1;
        reset = 1'b1;
        cycle(4'b0000, '0, "unconfigured_no_ack");
        cycle(4'b0000, '0, "unconfigured_no_ack");
        chk("unconfigured_no_pkt", {63'd0, dout_bft[48]}, 64'd0);
        vld_user = '0;
        set_dest(4'd0, 4'h7, 4'h3);
        vld_user = 4'b0001; din_user[31:0] = 32'h7777_0000;
        cycle(4'b0001, mkpkt(0), "post_reset_send");
        vld_user = '0;
        cycle(4'b0000, '0, "final_idle");
        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
